sdram_init_monitor: RTL and testbench



---
 rtl/sdram_pkg.sv | 35 +++
 rtl/sdram_init_monitor_if.sv | 24 ++
 rtl/sdram_gap_counter.sv | 34 +++
 rtl/sdram_init_monitor.sv | 129 ++++++++++++
 tb/tb_sdram_init_monitor.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, init-monitor error codes and monitor states.
// Types and constants only; no latency, no backpressure.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PWR      = 3'd1,
    ERR_TRP      = 3'd2,
    ERR_TRFC     = 3'd3,
    ERR_TMRD     = 3'd4,
    ERR_ORDER    = 3'd5,
    ERR_PRE_BANK = 3'd6,
    ERR_BAD_MRS  = 3'd7
  } err_code_e;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_TRP,
    ST_REFRESH,
    ST_MRD,
    ST_DONE,
    ST_ERR
  } mon_state_e;

  // DESELECT (cs_n high) counts as a NOP regardless of the other strobes.
  function automatic logic is_nop(input logic [3:0] cmd);
    return cmd[3] || (cmd == CMD_NOP);
  endfunction

endpackage

// File: rtl/sdram_init_monitor_if.sv
// Controller-to-SDRAM command bus as seen by the init monitor, plus monitor status.
// Wires only; no latency, no backpressure.
interface sdram_init_monitor_if;
  logic [3:0]  cmd_in;
  logic [1:0]  bank_in;
  logic [11:0] addr_in;
  logic        mon_done;
  logic        mon_err;
  logic [2:0]  err_code;
  logic [2:0]  mode_cl;
  logic        mode_bt;
  logic [2:0]  mode_bl;
  logic [3:0]  ref_count;

  modport master (
    output cmd_in, bank_in, addr_in,
    input  mon_done, mon_err, err_code, mode_cl, mode_bt, mode_bl, ref_count
  );

  modport slave (
    input  cmd_in, bank_in, addr_in,
    output mon_done, mon_err, err_code, mode_cl, mode_bt, mode_bl, ref_count
  );
endinterface

// File: rtl/sdram_gap_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Count visible one cycle after the enabling cycle; no backpressure.
module sdram_gap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sdram_init_monitor.sv
// Passive checker of the SDRAM power-up sequence (wait, PRE ALL, N x REF, MRS).
// Outputs registered, one cycle after the sampled command; never backpressures.
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int unsigned T_PWR = 15000,
  parameter int unsigned T_RP  = 2,
  parameter int unsigned T_RFC = 7,
  parameter int unsigned T_MRD = 2,
  parameter int unsigned N_REF = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  sdram_init_monitor_if.slave  mon
);

  localparam logic [15:0] T_PWR_W = 16'(T_PWR);
  localparam logic [15:0] T_RP_W  = 16'(T_RP);
  localparam logic [15:0] T_RFC_W = 16'(T_RFC);
  localparam logic [16:0] T_MRD_W = 17'(T_MRD);
  localparam logic [4:0]  N_REF_W = 5'(N_REF);

  mon_state_e state_q, state_d;
  err_code_e  err_code_q, err_code_d, fault;
  logic [3:0] ref_count_q, ref_count_d;
  logic [2:0] mode_cl_q, mode_cl_d, mode_bl_q, mode_bl_d;
  logic       mode_bt_q, mode_bt_d;
  logic       mon_done_q, mon_done_d, mon_err_q, mon_err_d;
  logic       nop, mrs_ok, ref_inc;
  logic [15:0] gap;

  assign nop    = is_nop(mon.cmd_in);
  assign mrs_ok = (mon.bank_in == 2'b00) && (mon.addr_in[11:7] == 5'd0);

  sdram_gap_counter #(.W(16)) u_gap (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (!nop),
    .inc   (nop),
    .cnt   (gap)
  );

  // Checks are ordered so timing faults win over 6/7, which win over 5.
  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    ref_count_d = ref_count_q;
    mode_cl_d   = mode_cl_q;
    mode_bt_d   = mode_bt_q;
    mode_bl_d   = mode_bl_q;
    fault       = ERR_NONE;
    ref_inc     = 1'b0;
    case (state_q)
      ST_PWR_WAIT: if (!nop) begin
        if (gap < T_PWR_W)                     fault = ERR_PWR;
        else if (mon.cmd_in != CMD_PRECHARGE)  fault = ERR_ORDER;
        else if (!mon.addr_in[10])             fault = ERR_PRE_BANK;
        else                                   state_d = ST_TRP;
      end
      ST_TRP: if (!nop) begin
        if (gap < T_RP_W)                      fault = ERR_TRP;
        else if (mon.cmd_in != CMD_AUTO_REF)   fault = ERR_ORDER;
        else begin
          state_d = ST_REFRESH;
          ref_inc = 1'b1;
        end
      end
      ST_REFRESH: if (!nop) begin
        if (gap < T_RFC_W)                     fault = ERR_TRFC;
        else if (mon.cmd_in == CMD_AUTO_REF)   ref_inc = 1'b1;
        else if (mon.cmd_in == CMD_MRS) begin
          if (!mrs_ok)                                fault = ERR_BAD_MRS;
          else if ({1'b0, ref_count_q} < N_REF_W)     fault = ERR_ORDER;
          else begin
            mode_cl_d = mon.addr_in[6:4];
            mode_bt_d = mon.addr_in[3];
            mode_bl_d = mon.addr_in[2:0];
            state_d   = ST_MRD;
          end
        end else                               fault = ERR_ORDER;
      end
      ST_MRD: begin
        if (!nop)                                   fault = ERR_TMRD;
        else if (({1'b0, gap} + 17'd1) >= T_MRD_W)  state_d = ST_DONE;
      end
      default: ;
    endcase
    if (ref_inc && (ref_count_q != 4'hF)) begin
      ref_count_d = ref_count_q + 4'd1;
    end
    if (fault != ERR_NONE) begin
      state_d    = ST_ERR;
      err_code_d = fault;
    end
    mon_done_d = (state_d == ST_DONE);
    mon_err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_PWR_WAIT;
      err_code_q  <= ERR_NONE;
      ref_count_q <= 4'd0;
      mode_cl_q   <= 3'd0;
      mode_bt_q   <= 1'b0;
      mode_bl_q   <= 3'd0;
      mon_done_q  <= 1'b0;
      mon_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      ref_count_q <= ref_count_d;
      mode_cl_q   <= mode_cl_d;
      mode_bt_q   <= mode_bt_d;
      mode_bl_q   <= mode_bl_d;
      mon_done_q  <= mon_done_d;
      mon_err_q   <= mon_err_d;
    end
  end

  assign mon.mon_done  = mon_done_q;
  assign mon.mon_err   = mon_err_q;
  assign mon.err_code  = err_code_q;
  assign mon.mode_cl   = mode_cl_q;
  assign mon.mode_bt   = mode_bt_q;
  assign mon.mode_bl   = mode_bl_q;
  assign mon.ref_count = ref_count_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: directed sequences plus randomized sequences
// scored against a command-level model of the init rules.
module tb_sdram_init_monitor;
  import sdram_pkg::*;

  localparam int TPWR = 300;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int TMRD = 2;
  localparam int NREF = 8;

  typedef struct {
    int         gap;
    logic [3:0] cmd;
    logic [1:0] bank;
    logic [11:0] addr;
  } item_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  item_t seq[$];

  logic       e_done, e_err, e_bt;
  logic [2:0] e_code, e_cl, e_bl;
  logic [3:0] e_refs;

  sdram_init_monitor_if bus();

  sdram_init_monitor #(
    .T_PWR(TPWR), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD), .N_REF(NREF)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mon       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    bus.cmd_in  = c;
    bus.bank_in = b;
    bus.addr_in = a;
    @(negedge sys_clk);
  endtask

  task automatic drive_nop();
    logic [3:0] c;
    c = ($urandom_range(0, 1) == 0) ? CMD_NOP : {1'b1, 3'($urandom)};
    drive(c, 2'($urandom), 12'($urandom));
  endtask

  // Leaves the bench at a negedge with reset just released, so the next
  // drive is the first cycle counted toward the power-on wait.
  task automatic do_reset();
    bus.cmd_in  = CMD_NOP;
    bus.bank_in = 2'b00;
    bus.addr_in = 12'h000;
    sys_rst_n   = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n   = 1'b1;
  endtask

  task automatic add(input int g, input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    item_t it;
    it.gap = g; it.cmd = c; it.bank = b; it.addr = a;
    seq.push_back(it);
  endtask

  task automatic add_prefix(input int nrefs);
    add(TPWR, CMD_PRECHARGE, 2'b00, 12'hFFF);
    for (int i = 0; i < nrefs; i++) add((i == 0) ? TRP : TRFC, CMD_AUTO_REF, 2'b00, 12'h000);
  endtask

  task automatic run_seq(input int trailing);
    for (int i = 0; i < seq.size(); i++) begin
      repeat (seq[i].gap) drive_nop();
      drive(seq[i].cmd, seq[i].bank, seq[i].addr);
    end
    repeat (trailing) drive_nop();
  endtask

  // Walks the command list phase by phase: power-on, precharge, refreshes, MRS.
  task automatic model(input int trailing);
    int refs;
    bit pre, mrs, done;
    logic [2:0] code;
    item_t it;
    refs = 0; pre = 0; mrs = 0; done = 0; code = 3'd0;
    e_cl = 3'd0; e_bt = 1'b0; e_bl = 3'd0;
    for (int i = 0; i < seq.size(); i++) begin
      if (code != 3'd0 || done) break;
      it = seq[i];
      if (mrs) begin
        if (it.gap >= TMRD) done = 1; else code = 3'd4;
      end else if (!pre) begin
        if (it.gap < TPWR) code = 3'd1;
        else if (it.cmd != CMD_PRECHARGE) code = 3'd5;
        else if (it.addr[10] == 1'b0) code = 3'd6;
        else pre = 1;
      end else if (refs == 0) begin
        if (it.gap < TRP) code = 3'd2;
        else if (it.cmd != CMD_AUTO_REF) code = 3'd5;
        else refs = 1;
      end else begin
        if (it.gap < TRFC) code = 3'd3;
        else if (it.cmd == CMD_AUTO_REF) refs = (refs < 15) ? refs + 1 : 15;
        else if (it.cmd == CMD_MRS) begin
          if (it.bank != 2'b00 || it.addr[11:7] != 5'd0) code = 3'd7;
          else if (refs < NREF) code = 3'd5;
          else begin
            mrs = 1;
            e_cl = it.addr[6:4]; e_bt = it.addr[3]; e_bl = it.addr[2:0];
          end
        end else code = 3'd5;
      end
    end
    if (mrs && code == 3'd0 && !done && trailing >= TMRD) done = 1;
    e_code = code;
    e_err  = (code != 3'd0);
    e_done = done && (code == 3'd0);
    e_refs = 4'(refs);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    bus.cmd_in = CMD_NOP; bus.bank_in = 2'b00; bus.addr_in = 12'h000;
    @(negedge sys_clk);
    checks++;
    if ({bus.mon_done, bus.mon_err, bus.err_code, bus.mode_cl, bus.mode_bt, bus.mode_bl, bus.ref_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got done=%0b err=%0b code=%0d refs=%0d want all 0",
               bus.mon_done, bus.mon_err, bus.err_code, bus.ref_count);
    end
  endtask

  task automatic test_legal();
    seq.delete(); do_reset();
    add_prefix(NREF);
    add(TRFC, CMD_MRS, 2'b00, 12'h037);
    run_seq(TMRD);
    checks++; if (bus.mon_done !== 1'b1) begin errors++; $display("FAIL legal_done got=%0b want=1", bus.mon_done); end
    checks++; if (bus.mon_err !== 1'b0) begin errors++; $display("FAIL legal_err got=%0b want=0", bus.mon_err); end
    checks++; if (bus.mode_cl !== 3'd3) begin errors++; $display("FAIL legal_cl got=%0d want=3", bus.mode_cl); end
    checks++; if (bus.mode_bt !== 1'b0) begin errors++; $display("FAIL legal_bt got=%0b want=0", bus.mode_bt); end
    checks++; if (bus.mode_bl !== 3'd7) begin errors++; $display("FAIL legal_bl got=%0d want=7", bus.mode_bl); end
    checks++; if (bus.ref_count !== 4'd8) begin errors++; $display("FAIL legal_refs got=%0d want=8", bus.ref_count); end
  endtask

  task automatic test_mrd_edge();
    seq.delete(); do_reset();
    add_prefix(NREF);
    add(TRFC, CMD_MRS, 2'b00, 12'h022);
    run_seq(TMRD - 1);
    checks++; if (bus.mon_done !== 1'b0) begin errors++; $display("FAIL mrd_early_done got=%0b want=0", bus.mon_done); end
    drive_nop();
    checks++; if (bus.mon_done !== 1'b1) begin errors++; $display("FAIL mrd_edge_done got=%0b want=1", bus.mon_done); end
  endtask

  task automatic test_violation(input string name, input int nrefs, input int kind, input logic [2:0] want);
    seq.delete(); do_reset();
    case (kind)
      0: add(TPWR - 1, CMD_PRECHARGE, 2'b00, 12'hFFF);
      1: begin add(TPWR, CMD_PRECHARGE, 2'b00, 12'hFFF); add(1, CMD_AUTO_REF, 2'b00, 12'h000); end
      2: begin add_prefix(nrefs); add(TRFC - 1, CMD_AUTO_REF, 2'b00, 12'h000); end
      3: begin add_prefix(nrefs); add(TRFC, CMD_MRS, 2'b00, 12'h037); end
      4: begin add_prefix(nrefs); add(TRFC, CMD_MRS, 2'b01, 12'h037); end
      5: begin add(TPWR, CMD_PRECHARGE, 2'b00, 12'hFFF); add(TRP, 4'b0011, 2'b00, 12'h000); end
      6: add(TPWR, CMD_PRECHARGE, 2'b00, 12'h000);
      default: begin add_prefix(nrefs); add(TRFC, CMD_MRS, 2'b00, 12'h037); add(1, CMD_AUTO_REF, 2'b00, 12'h000); end
    endcase
    run_seq(TMRD + 1);
    checks++;
    if (bus.err_code !== want || bus.mon_err !== 1'b1 || bus.mon_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got code=%0d err=%0b done=%0b want code=%0d err=1 done=0",
               name, bus.err_code, bus.mon_err, bus.mon_done, want);
    end
  endtask

  task automatic test_reset_mid();
    seq.delete(); do_reset();
    add_prefix(4);
    run_seq(3);
    checks++; if (bus.ref_count !== 4'd4) begin errors++; $display("FAIL mid_refs got=%0d want=4", bus.ref_count); end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({bus.mon_done, bus.mon_err, bus.err_code, bus.mode_cl, bus.mode_bt, bus.mode_bl, bus.ref_count} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset got done=%0b err=%0b code=%0d refs=%0d want all 0",
               bus.mon_done, bus.mon_err, bus.err_code, bus.ref_count);
    end
    seq.delete(); do_reset();
    add_prefix(NREF);
    add(TRFC, CMD_MRS, 2'b00, 12'h037);
    run_seq(TMRD);
    checks++; if (bus.mon_done !== 1'b1 || bus.mon_err !== 1'b0) begin errors++; $display("FAIL after_reset_done got done=%0b err=%0b want done=1 err=0", bus.mon_done, bus.mon_err); end
  endtask

  task automatic test_random(input int iters);
    int nrefs, idx, trailing, mode;
    for (int it = 0; it < iters; it++) begin
      seq.delete(); do_reset();
      nrefs = NREF + $urandom_range(0, 3);
      add(TPWR + $urandom_range(0, 2), CMD_PRECHARGE, 2'b00, 12'($urandom) | 12'h400);
      for (int r = 0; r < nrefs; r++)
        add(((r == 0) ? TRP : TRFC) + $urandom_range(0, 2), CMD_AUTO_REF, 2'($urandom), 12'($urandom));
      add(TRFC + $urandom_range(0, 2), CMD_MRS, 2'b00, {5'd0, 7'($urandom)});
      mode = $urandom_range(0, 3);
      idx  = $urandom_range(0, seq.size() - 1);
      if (mode == 1) seq[idx].gap = $urandom_range(0, seq[idx].gap);
      if (mode == 2) begin
        seq[idx].cmd  = 4'($urandom_range(0, 6));
        seq[idx].bank = 2'($urandom);
        seq[idx].addr = 12'($urandom);
      end
      if (mode == 3) add($urandom_range(0, 3), 4'($urandom_range(0, 6)), 2'($urandom), 12'($urandom));
      trailing = $urandom_range(0, 3);
      run_seq(trailing);
      model(trailing);
      checks++; if (bus.mon_done !== e_done) begin errors++; $display("FAIL rand%0d done got=%0b want=%0b", it, bus.mon_done, e_done); end
      checks++; if (bus.mon_err !== e_err) begin errors++; $display("FAIL rand%0d err got=%0b want=%0b", it, bus.mon_err, e_err); end
      checks++; if (bus.err_code !== e_code) begin errors++; $display("FAIL rand%0d code got=%0d want=%0d", it, bus.err_code, e_code); end
      checks++; if (bus.ref_count !== e_refs) begin errors++; $display("FAIL rand%0d refs got=%0d want=%0d", it, bus.ref_count, e_refs); end
      checks++;
      if ({bus.mode_cl, bus.mode_bt, bus.mode_bl} !== {e_cl, e_bt, e_bl}) begin
        errors++;
        $display("FAIL rand%0d mode got=%0d/%0b/%0d want=%0d/%0b/%0d", it,
                 bus.mode_cl, bus.mode_bt, bus.mode_bl, e_cl, e_bt, e_bl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_mrd_edge();
    test_violation("pwr_early",  0,    0, 3'd1);
    test_violation("trp_short",  0,    1, 3'd2);
    test_violation("trfc_short", 1,    2, 3'd3);
    test_violation("mrs_7refs",  7,    3, 3'd5);
    test_violation("mrs_bank",   NREF, 4, 3'd7);
    test_violation("active_trp", 0,    5, 3'd5);
    test_violation("pre_a10",    0,    6, 3'd6);
    test_violation("tmrd_short", NREF, 7, 3'd4);
    test_reset_mid();
    test_random(25);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
